// File: rtl/oam_dma_arbiter.sv
// Shares the core's memory bus with a sprite-DMA engine. A CPU write to TRIG_ADDR
// copies DMA_LEN bytes from page {wdata,8'h00} to DEST_ADDR, stalling the core via cpu_rdy.
module oam_dma_arbiter #(
   parameter logic [15:0] TRIG_ADDR = 16'h4014,
   parameter logic [15:0] DEST_ADDR = 16'h2004,
   parameter int unsigned DMA_LEN   = 256
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_we,
   input  logic        cpu_re,
   input  logic [7:0]  mem_rdata,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   output logic        cpu_rdy,
   output logic        dma_active,
   output logic        dma_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE
   } state_t;

   // idx is one bit wider than a byte so DMA_LEN=256 terminates at 255 cleanly
   localparam logic [8:0] LAST_IDX = 9'(DMA_LEN - 1);

   state_t     state_q, state_d;
   logic       parity_q;
   logic [8:0] idx_q, idx_d;
   logic [7:0] page_q, page_d;
   logic       trig;
   logic       last;

   assign trig = cpu_we && (cpu_addr == TRIG_ADDR);
   assign last = (idx_q == LAST_IDX);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= S_IDLE;
         parity_q <= 1'b0;
         idx_q    <= '0;
         page_q   <= '0;
      end else begin
         state_q  <= state_d;
         parity_q <= ~parity_q;
         idx_q    <= idx_d;
         page_q   <= page_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      page_d  = page_q;
      case (state_q)
         S_IDLE: begin
            if (trig) begin
               state_d = S_HALT;
               page_d  = cpu_wdata;
               idx_d   = '0;
            end
         end
         // READ must land on a get cycle; parity==1 now means the next cycle is a get
         S_HALT:  state_d = parity_q ? S_READ : S_ALIGN;
         S_ALIGN: state_d = S_READ;
         S_READ:  state_d = S_WRITE;
         S_WRITE: begin
            if (last) begin
               state_d = S_IDLE;
            end else begin
               idx_d   = idx_q + 9'd1;
               state_d = S_READ;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_addr   = 16'h0000;
      mem_wdata  = 8'h00;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      cpu_rdy    = 1'b0;
      dma_active = 1'b1;
      dma_done   = 1'b0;
      case (state_q)
         S_IDLE: begin
            mem_addr   = cpu_addr;
            mem_wdata  = cpu_wdata;
            mem_we     = cpu_we;
            mem_re     = cpu_re;
            cpu_rdy    = 1'b1;
            dma_active = 1'b0;
         end
         S_READ: begin
            mem_addr = {page_q, idx_q[7:0]};
            mem_re   = 1'b1;
         end
         S_WRITE: begin
            // read data arrives this cycle and is forwarded without a register
            mem_addr  = DEST_ADDR;
            mem_wdata = mem_rdata;
            mem_we    = 1'b1;
            dma_done  = last;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: reset, passthrough, even/odd trigger timing,
// page wrap, ignored re-trigger, and reset abort followed by a fresh transfer.
module tb_oam_dma_arbiter;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_we;
   logic        cpu_re;
   logic [7:0]  mem_rdata;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic        cpu_rdy;
   logic        dma_active;
   logic        dma_done;

   logic [7:0]  ram [0:65535];

   oam_dma_arbiter dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_we     (cpu_we),
      .cpu_re     (cpu_re),
      .mem_rdata  (mem_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .cpu_rdy    (cpu_rdy),
      .dma_active (dma_active),
      .dma_done   (dma_done)
   );

   always #5 CLK = ~CLK;

   // synchronous-read memory: data valid the cycle after the address
   always @(posedge CLK) mem_rdata <= ram[mem_addr];

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   logic par = 1'b0;

   int          r_T, r_nwr, r_nrd, r_bad, r_ndone, r_done, r_rdy, r_frd, r_stall, r_wrap;
   logic [1:0]  r_k2;
   logic [15:0] r_last_ra;
   logic        r_to;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] src_byte(input logic [7:0] pg, input logic [7:0] i);
      return i ^ 8'h5A ^ (pg - 8'h02);
   endfunction

   // advance one cycle; par mirrors the DUT's free-running get/put toggle
   task automatic step();
      @(posedge CLK);
      if (RESET) par = ~par;
      else       par = 1'b0;
      cyc++;
      #1;
   endtask

   task automatic set_idle();
      cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
   endtask

   task automatic dma_run(input logic [7:0] pg, input logic want_par, input logic both,
                          input logic retrig, input int abort_at);
      set_idle();
      while (par !== want_par) step();
      cpu_we = 1'b1; cpu_re = both; cpu_addr = 16'h4014; cpu_wdata = pg;
      #1;
      chk("trig_write_passes", {mem_we, mem_addr}, {1'b1, 16'h4014});
      r_T = cyc; r_nwr = 0; r_nrd = 0; r_bad = 0; r_ndone = 0; r_done = -1; r_rdy = -1;
      r_frd = -1; r_stall = 0; r_wrap = 0; r_k2 = 2'b11; r_last_ra = 16'h0000; r_to = 1'b1;
      for (int k = 1; k <= 600; k++) begin
         step();
         set_idle();
         if (retrig && k >= 40 && k < 48) begin
            cpu_we = 1'b1; cpu_addr = 16'h4014; cpu_wdata = 8'h07;
         end
         if (abort_at >= 0 && r_nwr == abort_at) begin
            RESET = 1'b0;
            #1;
            chk("abort_rdy", cpu_rdy, 1);
            chk("abort_active", dma_active, 0);
            chk("abort_done", dma_done, 0);
            step(); step();
            RESET = 1'b1;
            r_to = 1'b0;
            break;
         end
         #1;
         if (mem_re) begin
            if (mem_addr !== {pg, 8'(r_nrd)}) r_bad++;
            if (mem_addr == 16'h0000 || mem_addr == 16'h0100) r_wrap++;
            if (r_nrd == 0) r_frd = cyc - r_T;
            r_last_ra = mem_addr;
            r_nrd++;
         end
         if (mem_we) begin
            if (mem_addr !== 16'h2004 || mem_wdata !== src_byte(pg, 8'(r_nwr))) r_bad++;
            r_nwr++;
         end
         if (dma_done) begin
            r_ndone++;
            r_done = cyc - r_T;
         end
         if (k == 2) r_k2 = {mem_re | mem_we, cpu_rdy};
         if (cpu_rdy) begin
            if (dma_active || dma_done) r_bad++;
            r_rdy = cyc - r_T;
            r_to = 1'b0;
            break;
         end
         r_stall++;
         if (!dma_active) r_bad++;
      end
      if (r_to) chk("dma_timeout", 1, 0);
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) ram[a] = src_byte(8'(a >> 8), 8'(a));
      set_idle();

      // reset holds the bus in passthrough regardless of core activity
      for (int i = 0; i < 6; i++) begin
         step();
         cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
         cpu_we = 1'($urandom); cpu_re = 1'($urandom);
         if (i == 2) begin cpu_we = 1'b1; cpu_addr = 16'h4014; end
         #1;
         chk("rst_rdy", cpu_rdy, 1);
         chk("rst_active", dma_active, 0);
         chk("rst_done", dma_done, 0);
         chk("rst_addr", mem_addr, cpu_addr);
      end
      set_idle();
      RESET = 1'b1;
      step();

      cpu_re = 1'b1; cpu_addr = 16'h1234;
      #1;
      chk("idle_read", {mem_re, mem_we, mem_addr}, {1'b1, 1'b0, 16'h1234});
      cpu_re = 1'b0; cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_wdata = 8'h3C;
      #1;
      chk("idle_write", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'h0300, 8'h3C});
      step();

      // even trigger: no align cycle
      dma_run(8'h02, 1'b0, 1'b0, 1'b0, -1);
      chk("even_nwr", r_nwr, 256);
      chk("even_bad", r_bad, 0);
      chk("even_ndone", r_ndone, 1);
      chk("even_done_at", r_done, 513);
      chk("even_rdy_at", r_rdy, 514);
      chk("even_first_read", r_frd, 2);
      chk("even_stall", r_stall, 513);
      chk("even_t2_bus", r_k2, 2'b10);

      // odd trigger with simultaneous read strobe still triggers
      dma_run(8'h02, 1'b1, 1'b1, 1'b0, -1);
      chk("odd_nwr", r_nwr, 256);
      chk("odd_bad", r_bad, 0);
      chk("odd_ndone", r_ndone, 1);
      chk("odd_done_at", r_done, 514);
      chk("odd_rdy_at", r_rdy, 515);
      chk("odd_first_read", r_frd, 3);
      chk("odd_stall", r_stall, 514);
      chk("odd_align_idle", r_k2, 2'b00);

      // page FF must not carry into the high byte
      dma_run(8'hFF, 1'b0, 1'b0, 1'b0, -1);
      chk("wrap_last_read", r_last_ra, 16'hFFFF);
      chk("wrap_no_spill", r_wrap, 0);
      chk("wrap_nwr", r_nwr, 256);
      chk("wrap_bad", r_bad, 0);

      dma_run(8'h02, 1'b0, 1'b0, 1'b1, -1);
      chk("retrig_nwr", r_nwr, 256);
      chk("retrig_ndone", r_ndone, 1);
      chk("retrig_bad", r_bad, 0);
      chk("retrig_last_read", r_last_ra, 16'h02FF);

      dma_run(8'h02, 1'b0, 1'b0, 1'b0, 100);
      chk("abort_nwr", r_nwr, 100);
      chk("abort_ndone", r_ndone, 0);

      // restart after abort begins again at idx 0
      dma_run(8'h02, 1'b1, 1'b0, 1'b0, -1);
      chk("restart_first_read", r_frd, 3);
      chk("restart_nwr", r_nwr, 256);
      chk("restart_bad", r_bad, 0);
      chk("restart_ndone", r_ndone, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Shares the single CPU memory bus between the 6502 core and a sprite-DMA engine.
- A CPU write to the trigger address starts a 256-byte block copy from page {data,8'h00} to the sprite data port.
- The CPU is held off through cpu_rdy for the whole copy.
- Sits between the core's bus outputs (address/MDR path) and system memory.
- The core's sequencer stalls on cpu_rdy=0.

Parameters:
- TRIG_ADDR, 16'h4014, CPU write address that starts DMA; the written byte is the source page.
- DEST_ADDR, 16'h2004, fixed destination address for every DMA write.
- DMA_LEN, 256, bytes per transfer, range 1..256.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- cpu_addr  in  16  core bus address.
- cpu_wdata  in  8  core write data.
- cpu_we  in  1  core write strobe.
- cpu_re  in  1  core read strobe.
- mem_rdata  in  8  memory read data; valid the cycle after a read address is presented.
- mem_addr  out  16  arbitrated bus address.
- mem_wdata  out  8  arbitrated write data.
- mem_we  out  1  arbitrated write strobe.
- mem_re  out  1  arbitrated read strobe.
- cpu_rdy  out  1  1 = core may advance; 0 = core stalls.
- dma_active  out  1  high from HALT through the final WRITE cycle.
- dma_done  out  1  single-cycle pulse during the final WRITE cycle.

Behaviour:
- Reset (RESET=0, asynchronous): state=IDLE, parity=0, idx=0, page=0. Outputs: cpu_rdy=1, dma_active=0, dma_done=0. Bus passes through the core.
- parity: free-running 1-bit toggle every cycle. 0 = get cycle, 1 = put cycle.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - mem_* = cpu_* combinationally; cpu_rdy=1.
  - If cpu_we && cpu_addr==TRIG_ADDR: the write still goes to memory that cycle, page <= cpu_wdata, idx <= 0, next=HALT.
- HALT:
  - cpu_rdy=0, dma_active=1, mem_we=mem_re=0.
  - next = ALIGN if the next cycle is a put cycle (parity==0 now), else READ.
- ALIGN: one idle bus cycle, cpu_rdy=0, no strobes; next=READ.
- READ: mem_addr={page,idx[7:0]}, mem_re=1, mem_we=0; next=WRITE.
- WRITE:
  - mem_addr=DEST_ADDR, mem_wdata=mem_rdata (pass-through, no extra latency), mem_we=1.
  - If idx==DMA_LEN-1: dma_done=1, next=IDLE.
  - Otherwise: idx<=idx+1, next=READ.
- cpu_rdy is combinational: 1 only in IDLE. Returns to 1 the cycle after the final WRITE.
- In all DMA states, cpu_* inputs are ignored, including further writes to TRIG_ADDR. No re-trigger and no queuing.
- idx is 9 bits wide, so DMA_LEN=256 ends at idx=255 without overflow. Source address low byte is idx[7:0]; the page never increments.
- Latency from trigger cycle T:
  - T even: READ at T+2, final WRITE at T+513, cpu_rdy=1 at T+514 (513 stall cycles).
  - T odd: ALIGN at T+2, cpu_rdy=1 at T+515 (514 stall cycles).
- Reset mid-DMA: abort immediately, return to IDLE, cpu_rdy=1, no dma_done.
- Simultaneous cpu_we && cpu_re at TRIG_ADDR: treated as a write (trigger).

Test Plan:
- Reset: hold RESET=0 with random cpu_*. Require cpu_rdy=1, dma_active=0, dma_done=0, and mem_addr equal to cpu_addr throughout.
- Even trigger: write 8'h02 to 16'h4014 on a parity-0 cycle with RAM[0x0200+i]=i^8'h5A. Require 256 writes to 16'h2004 carrying i^8'h5A in order, no ALIGN, dma_done at T+513, cpu_rdy=1 at T+514.
- Odd trigger: same transfer triggered on a parity-1 cycle. Require one idle cycle at T+2, first READ at address 16'h0200 at T+3, cpu_rdy=1 at T+515.
- Page wrap: page 8'hFF. Require the last read address 16'hFFFF and no read at 16'h0000 or 16'h0100.
- Re-trigger ignored: drive cpu_we=1, cpu_addr=16'h4014, cpu_wdata=8'h07 mid-DMA. Require page unchanged, exactly 256 writes, one dma_done.
- Reset mid-DMA: pull RESET low after 100 transfers. Require immediate IDLE, cpu_rdy=1, no dma_done. A new trigger then restarts from idx=0.
